// File: rtl/vz_image_loader_if.sv
// Download (hps_io ioctl) and RAM write-port bundle for the VZ snapshot loader.
// The loader takes the master view; hps_io and the RAM arbiter take the slave view.
interface vz_image_loader_if #(
  parameter int RAM_AW = 16
);
  logic              dn_download;
  logic [7:0]        dn_index;
  logic              dn_wr;
  logic [15:0]       dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wait;
  logic              ram_req;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_ack;

  modport master (
    input  dn_download, dn_index, dn_wr, dn_addr, dn_data, ram_ack,
    output dn_wait, ram_req, ram_addr, ram_dout
  );

  modport slave (
    output dn_download, dn_index, dn_wr, dn_addr, dn_data, ram_ack,
    input  dn_wait, ram_req, ram_addr, ram_dout
  );
endinterface

// File: rtl/vz_image_loader.sv
// VZ snapshot loader: parses the 24-byte header, streams the payload into RAM through a
// small FIFO and a req/ack port, then patches the BASIC end pointer (F0) or requests autorun (F1).
module vz_image_loader #(
  parameter int          RAM_AW       = 16,
  parameter logic [7:0]  F_INDEX      = 8'd1,
  parameter int          HDR_LEN      = 24,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] END_PTR_ADDR = 16'h78F9,
  parameter bit          CHECK_MAGIC  = 1'b1
) (
  input  logic              clk_sys_i,
  input  logic              reset_i,
  vz_image_loader_if.master bus,
  output logic              cpu_hold_o,
  output logic [7:0]        img_type_o,
  output logic [15:0]       start_addr_o,
  output logic [15:0]       end_addr_o,
  output logic              done_o,
  output logic              autorun_req_o,
  output logic              err_o
);

  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam int            CW        = PW + 1;
  localparam logic [15:0]   HDR_LAST  = 16'(HDR_LEN - 1);
  localparam logic [CW-1:0] FILL_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FILL_WAIT = CW'(FIFO_DEPTH - 1);
  localparam logic [7:0]    TYPE_F0   = 8'hF0;
  localparam logic [7:0]    TYPE_F1   = 8'hF1;
  localparam logic [31:0]   MAGIC_VZ  = 32'h565A4630;
  localparam logic [31:0]   MAGIC_ALT = 32'h20200000;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_DATA, S_DRAIN, S_PATCH_LO, S_PATCH_HI, S_DONE, S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic              dlPrev_q;
  logic              err_q, err_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       startAddr_q, startAddr_d;
  logic [15:0]       endAddr_q, endAddr_d;
  logic [7:0]        imgType_q, imgType_d;
  logic [31:0]       magic_q, magic_d;
  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic              req_q, req_d;
  logic [RAM_AW-1:0] ramAddr_q, ramAddr_d;
  logic [7:0]        ramData_q, ramData_d;
  logic              done_q, done_d;
  logic              autorun_q, autorun_d;

  logic [RAM_AW-1:0] fifoAddr_q [FIFO_DEPTH];
  logic [7:0]        fifoData_q [FIFO_DEPTH];

  logic              idxOk, startEv, fallEv, wrEv;
  logic              fifoEmpty, fifoFull;
  logic              push, pop, flush;
  logic              hdrOk;
  logic [RAM_AW-1:0] pushAddr;

  assign idxOk     = (bus.dn_index == F_INDEX);
  assign startEv   = bus.dn_download && !dlPrev_q && idxOk &&
                     (state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign fallEv    = !bus.dn_download && dlPrev_q;
  assign wrEv      = bus.dn_wr && idxOk;
  assign fifoEmpty = (fill_q == '0);
  assign fifoFull  = (fill_q == FILL_FULL);
  assign pushAddr  = RAM_AW'(startAddr_q) + RAM_AW'(count_q);
  assign hdrOk     = (!CHECK_MAGIC || magic_q == MAGIC_VZ || magic_q == MAGIC_ALT) &&
                     (imgType_q == TYPE_F0 || imgType_q == TYPE_F1);

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    count_d     = count_q;
    startAddr_d = startAddr_q;
    endAddr_d   = endAddr_q;
    imgType_d   = imgType_q;
    magic_d     = magic_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    fill_d      = fill_q;
    req_d       = req_q;
    ramAddr_d   = ramAddr_q;
    ramData_d   = ramData_q;
    done_d      = 1'b0;
    autorun_d   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;

    case (state_q)
      S_HEADER: begin
        if (fallEv) begin
          state_d = S_ERROR;
        end else if (wrEv && bus.dn_addr <= HDR_LAST) begin
          case (bus.dn_addr)
            16'd0:   magic_d[31:24]     = bus.dn_data;
            16'd1:   magic_d[23:16]     = bus.dn_data;
            16'd2:   magic_d[15:8]      = bus.dn_data;
            16'd3:   magic_d[7:0]       = bus.dn_data;
            16'd21:  imgType_d          = bus.dn_data;
            16'd22:  startAddr_d[7:0]   = bus.dn_data;
            16'd23:  startAddr_d[15:8]  = bus.dn_data;
            default: ;
          endcase
          // Magic and type bytes all precede the last header byte, so the registered copies are complete here.
          if (bus.dn_addr == HDR_LAST) begin
            state_d = hdrOk ? S_DATA : S_ERROR;
          end
        end
      end
      S_DATA: begin
        if (wrEv) begin
          count_d = count_q + 16'd1;
          if (fifoFull) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        if (fallEv) begin
          state_d   = S_DRAIN;
          endAddr_d = startAddr_q + count_d;
        end
      end
      S_DRAIN: begin
        if (fifoEmpty && !req_q) begin
          state_d = (imgType_q == TYPE_F0) ? S_PATCH_LO : S_DONE;
        end
      end
      S_PATCH_LO: begin
        if (req_q && bus.ram_ack) begin
          state_d = S_PATCH_HI;
        end
      end
      S_PATCH_HI: begin
        if (req_q && bus.ram_ack) begin
          state_d = S_DONE;
        end
      end
      default: ;
    endcase

    // A request is always followed by at least one idle cycle before the next one is issued.
    if (req_q && bus.ram_ack) begin
      req_d = 1'b0;
      if (state_q inside {S_DATA, S_DRAIN}) begin
        pop = 1'b1;
      end
    end else if (!req_q) begin
      if ((state_q inside {S_DATA, S_DRAIN}) && !fifoEmpty) begin
        req_d     = 1'b1;
        ramAddr_d = fifoAddr_q[rdPtr_q];
        ramData_d = fifoData_q[rdPtr_q];
      end else if (state_q == S_PATCH_LO) begin
        req_d     = 1'b1;
        ramAddr_d = RAM_AW'(END_PTR_ADDR);
        ramData_d = endAddr_q[7:0];
      end else if (state_q == S_PATCH_HI) begin
        req_d     = 1'b1;
        ramAddr_d = RAM_AW'(END_PTR_ADDR + 16'd1);
        ramData_d = endAddr_q[15:8];
      end
    end

    if (state_d == S_ERROR && state_q != S_ERROR) begin
      flush = 1'b1;
      req_d = 1'b0;
      err_d = 1'b1;
    end

    if (startEv) begin
      state_d = S_HEADER;
      err_d   = 1'b0;
      count_d = '0;
      flush   = 1'b1;
      req_d   = 1'b0;
    end

    if (state_d == S_DONE && state_q != S_DONE) begin
      done_d    = 1'b1;
      autorun_d = (imgType_q == TYPE_F1);
    end

    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      fill_d  = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)  rdPtr_d = rdPtr_q + PW'(1);
      fill_d = fill_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      dlPrev_q    <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
      startAddr_q <= '0;
      endAddr_q   <= '0;
      imgType_q   <= '0;
      magic_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fill_q      <= '0;
      req_q       <= 1'b0;
      ramAddr_q   <= '0;
      ramData_q   <= '0;
      done_q      <= 1'b0;
      autorun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dlPrev_q    <= bus.dn_download;
      err_q       <= err_d;
      count_q     <= count_d;
      startAddr_q <= startAddr_d;
      endAddr_q   <= endAddr_d;
      imgType_q   <= imgType_d;
      magic_q     <= magic_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fill_q      <= fill_d;
      req_q       <= req_d;
      ramAddr_q   <= ramAddr_d;
      ramData_q   <= ramData_d;
      done_q      <= done_d;
      autorun_q   <= autorun_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers alone.
  always_ff @(posedge clk_sys_i) begin
    if (push) begin
      fifoAddr_q[wrPtr_q] <= pushAddr;
      fifoData_q[wrPtr_q] <= bus.dn_data;
    end
  end

  assign bus.dn_wait    = (fill_q >= FILL_WAIT);
  assign bus.ram_req    = req_q;
  assign bus.ram_addr   = ramAddr_q;
  assign bus.ram_dout   = ramData_q;
  assign cpu_hold_o     = state_q inside {S_HEADER, S_DATA, S_DRAIN, S_PATCH_LO, S_PATCH_HI};
  assign img_type_o     = imgType_q;
  assign start_addr_o   = startAddr_q;
  assign end_addr_o     = endAddr_q;
  assign done_o         = done_q;
  assign autorun_req_o  = autorun_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_vz_image_loader.sv
// Self-checking bench for vz_image_loader: directed and randomized downloads compared
// against a file-level model of the RAM writes each snapshot should produce.
module tb_vz_image_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpuHold;
  logic [7:0]  imgType;
  logic [15:0] startAddr;
  logic [15:0] endAddr;
  logic        done;
  logic        autorun;
  logic        err;

  always #5 clock = ~clock;

  vz_image_loader_if #(.RAM_AW(16)) bus ();

  vz_image_loader dut (
    .clk_sys_i     (clock),
    .reset_i       (reset),
    .bus           (bus),
    .cpu_hold_o    (cpuHold),
    .img_type_o    (imgType),
    .start_addr_o  (startAddr),
    .end_addr_o    (endAddr),
    .done_o        (done),
    .autorun_req_o (autorun),
    .err_o         (err)
  );

  int compareCount = 0;
  int failCount    = 0;

  logic [23:0] expQ [$];
  logic [23:0] obsQ [$];
  bit          expErr;
  logic [7:0]  expType;
  logic [15:0] expStart;
  logic [15:0] expEnd;

  int          ackMin = 0;
  int          ackMax = 0;
  bit          spurious = 1'b0;
  bit          pending = 1'b0;
  bit          ackGiven = 1'b0;
  int          waitCnt = 0;
  logic [15:0] lastAddr;
  logic [7:0]  lastData;
  int          reqCycles = 0;
  int          doneCount = 0;
  int          autorunCount = 0;
  bit          sawWait = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    compareCount++;
    failCount++;
    $error("[TB] FAIL %s observed=timeout expected=event", tag);
  endtask

  // RAM arbiter model: acks after a random delay, logs accepted writes, pokes stray acks while idle.
  always @(negedge clock) begin
    if (reset) begin
      bus.ram_ack = 1'b0;
      pending     = 1'b0;
      ackGiven    = 1'b0;
    end else begin
      if (bus.dn_wait) sawWait = 1'b1;
      if (done) doneCount++;
      if (autorun) autorunCount++;
      if (ackGiven) begin
        ackGiven = 1'b0;
        pending  = 1'b0;
      end
      if (bus.ram_req) begin
        reqCycles++;
        if (!pending) begin
          pending  = 1'b1;
          waitCnt  = int'($urandom_range(ackMax, ackMin));
          lastAddr = bus.ram_addr;
          lastData = bus.ram_dout;
        end else begin
          checkOutput("ramAddrStable", 32'(bus.ram_addr), 32'(lastAddr));
          checkOutput("ramDataStable", 32'(bus.ram_dout), 32'(lastData));
        end
        if (waitCnt == 0) begin
          bus.ram_ack = 1'b1;
          ackGiven    = 1'b1;
          obsQ.push_back({bus.ram_addr, bus.ram_dout});
        end else begin
          bus.ram_ack = 1'b0;
          waitCnt--;
        end
      end else begin
        bus.ram_ack = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sendByte(input logic [15:0] a, input logic [7:0] d, input bit honourWait);
    int guard = 0;
    if (honourWait) begin
      while (bus.dn_wait && guard < 500) begin
        tick();
        guard++;
      end
      if (guard >= 500) timeoutFail("dnWaitBound");
    end
    bus.dn_addr = a;
    bus.dn_data = d;
    bus.dn_wr   = 1'b1;
    tick();
    bus.dn_wr   = 1'b0;
    repeat ($urandom_range(2, 0)) tick();
  endtask

  // magicSel: 0 = "VZF0", 1 = 20,20,00,00, 2 = "ABCD". cutAt >= 0 ends the download after that header byte.
  task automatic applyStimulus(input logic [7:0] typ, input logic [15:0] start, input int n,
                               input int magicSel, input int cutAt);
    logic [7:0]  hdr [24];
    logic [7:0]  pay [$];
    logic [31:0] mg;
    bit          hdrValid;
    expQ.delete();
    obsQ.delete();
    reqCycles    = 0;
    doneCount    = 0;
    autorunCount = 0;
    sawWait      = 1'b0;
    case (magicSel)
      0:       mg = 32'h565A4630;
      1:       mg = 32'h20200000;
      default: mg = 32'h41424344;
    endcase
    for (int i = 0; i < 24; i++) hdr[i] = 8'($urandom);
    hdr[0]  = mg[31:24];
    hdr[1]  = mg[23:16];
    hdr[2]  = mg[15:8];
    hdr[3]  = mg[7:0];
    hdr[21] = typ;
    hdr[22] = start[7:0];
    hdr[23] = start[15:8];
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));

    hdrValid = (magicSel != 2) && (typ == 8'hF0 || typ == 8'hF1);
    expErr   = !(hdrValid && cutAt < 0);
    expType  = typ;
    expStart = start;
    expEnd   = start + 16'(n);
    if (!expErr) begin
      for (int i = 0; i < n; i++) expQ.push_back({start + 16'(i), pay[i]});
      if (typ == 8'hF0) begin
        expQ.push_back({16'h78F9, expEnd[7:0]});
        expQ.push_back({16'h78FA, expEnd[15:8]});
      end
    end

    bus.dn_index    = 8'd1;
    bus.dn_download = 1'b1;
    tick();
    for (int i = 0; i < 24; i++) begin
      if (cutAt < 0 || i <= cutAt) sendByte(16'(i), hdr[i], 1'b0);
    end
    if (cutAt < 0) begin
      checkOutput("cpuHoldAfterHeader", 32'(cpuHold), 32'(hdrValid));
      for (int i = 0; i < n; i++) sendByte(16'(24 + i), pay[i], 1'b1);
    end
    bus.dn_download = 1'b0;
    tick();
  endtask

  task automatic checkLoad(input string tag);
    int g = 0;
    while (!(doneCount > 0 || err === 1'b1) && g < 4000) begin
      tick();
      g++;
    end
    if (g >= 4000) timeoutFail({tag, ".completion"});
    repeat (4) tick();
    checkOutput({tag, ".err"}, 32'(err), 32'(expErr));
    checkOutput({tag, ".cpuHold"}, 32'(cpuHold), 32'd0);
    checkOutput({tag, ".doneCount"}, 32'(doneCount), expErr ? 32'd0 : 32'd1);
    checkOutput({tag, ".autorunCount"}, 32'(autorunCount),
                (!expErr && expType == 8'hF1) ? 32'd1 : 32'd0);
    checkOutput({tag, ".nWrites"}, 32'(obsQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      checkOutput($sformatf("%s.write%0d", tag, i), 32'(obsQ[i]), 32'(expQ[i]));
    if (expErr) begin
      checkOutput({tag, ".reqCycles"}, 32'(reqCycles), 32'd0);
    end else begin
      checkOutput({tag, ".imgType"}, 32'(imgType), 32'(expType));
      checkOutput({tag, ".startAddr"}, 32'(startAddr), 32'(expStart));
      checkOutput({tag, ".endAddr"}, 32'(endAddr), 32'(expEnd));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".cpuHold"}, 32'(cpuHold), 32'd0);
    checkOutput({tag, ".ramReq"}, 32'(bus.ram_req), 32'd0);
    checkOutput({tag, ".ramAddr"}, 32'(bus.ram_addr), 32'd0);
    checkOutput({tag, ".ramDout"}, 32'(bus.ram_dout), 32'd0);
    checkOutput({tag, ".dnWait"}, 32'(bus.dn_wait), 32'd0);
    checkOutput({tag, ".done"}, 32'(done), 32'd0);
    checkOutput({tag, ".autorun"}, 32'(autorun), 32'd0);
    checkOutput({tag, ".err"}, 32'(err), 32'd0);
    checkOutput({tag, ".imgType"}, 32'(imgType), 32'd0);
    checkOutput({tag, ".startAddr"}, 32'(startAddr), 32'd0);
    checkOutput({tag, ".endAddr"}, 32'(endAddr), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    reset           = 1'b1;
    bus.dn_download = 1'b0;
    bus.dn_index    = 8'd0;
    bus.dn_wr       = 1'b0;
    bus.dn_addr     = 16'd0;
    bus.dn_data     = 8'd0;
    #22;
    checkAllZero("reset");
    @(negedge clock);
    reset = 1'b0;
    tick();

    $display("[TB] directed F0 load at 7AE9, immediate ack");
    ackMin = 0; ackMax = 0; spurious = 1'b0;
    applyStimulus(8'hF0, 16'h7AE9, 3, 0, -1);
    checkLoad("f0Basic");

    $display("[TB] F1 load with 20-cycle ack stall");
    ackMin = 20; ackMax = 20;
    applyStimulus(8'hF1, 16'h8000, 6, 1, -1);
    checkLoad("f1Stall");
    checkOutput("f1Stall.sawWait", 32'(sawWait), 32'd1);

    $display("[TB] address wrap at FFFE");
    ackMin = 0; ackMax = 2; spurious = 1'b1;
    applyStimulus(8'hF0, 16'hFFFE, 4, 0, -1);
    checkLoad("wrap");

    $display("[TB] download cut inside header");
    applyStimulus(8'hF0, 16'h7000, 0, 0, 10);
    checkLoad("cutHeader");

    $display("[TB] bad magic and bad type");
    applyStimulus(8'hF0, 16'h7000, 3, 2, -1);
    checkLoad("badMagic");
    applyStimulus(8'h55, 16'h7000, 3, 0, -1);
    checkLoad("badType");

    $display("[TB] zero-length F0 payload");
    applyStimulus(8'hF0, 16'h1234, 0, 1, -1);
    checkLoad("zeroLen");

    $display("[TB] randomized downloads");
    for (int k = 0; k < 6; k++) begin
      ackMin = 0;
      ackMax = int'($urandom_range(3, 0));
      applyStimulus(($urandom_range(1, 0) == 1) ? 8'hF1 : 8'hF0, 16'($urandom),
                    int'($urandom_range(12, 0)), k % 2, -1);
      checkLoad($sformatf("rand%0d", k));
    end

    $display("[TB] reset during a stalled load");
    ackMin = 200; ackMax = 200; spurious = 1'b0;
    applyStimulus(8'hF0, 16'h9000, 3, 0, -1);
    g = 0;
    while (!bus.ram_req && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) timeoutFail("midReset.reqSeen");
    @(negedge clock);
    #1 reset = 1'b1;
    #1 checkAllZero("midReset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    tick();
    ackMin = 0; ackMax = 1;
    applyStimulus(8'hF0, 16'h7AE9, 5, 0, -1);
    checkLoad("afterReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
